imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writer side of the 16-bit instruction memory that the pipeline fetch stage reads
//  (address/clock/q port).
//  Accepts a byte stream on a valid/ready handshake and assembles bytes big-endian
//  into 16-bit instruction words.
//  Writes each word through the memory write port (address/data/wren) at
//  consecutive addresses, then flags done.
//  The top level holds the processor in reset while busy is high.
// PARAMETERS
//  ADDR_W     10        instruction memory address width
//  BASE_ADDR  0         first address written after load_start
//  MAX_WORDS  1024      words written before a forced stop (full)
//  END_WORD   16'hFFFF  terminator word; ends the load and is not written
// PORTS
//  clock        in   1       system clock; all state updates on posedge
//  reset_n      in   1       asynchronous active-low reset
//  load_start   in   1       1-cycle pulse; begins a load; ignored while busy
//  in_valid     in   1       in_byte holds a valid byte
//  in_byte      in   8       stream byte; high byte first, then low byte
//  in_ready     out  1       loader accepts a byte this cycle
//  mem_address  out  ADDR_W  write address to instruction memory
//  mem_data     out  16      write data to instruction memory
//  mem_wren     out  1       write enable; 1-cycle pulse per word
//  busy         out  1       load in progress (states HI, LO, WRITE)
//  done         out  1       load finished; held until next load_start or reset
//  full         out  1       load stopped by MAX_WORDS; valid while done=1
//  word_count   out  ADDR_W+1  number of words written by the current/last load
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE.
//   All outputs are 0: in_ready, mem_address, mem_data, mem_wren, busy, done,
//   full, word_count.
//   Reset mid-load aborts immediately; mem_wren drops with reset; no partial word
//   is written.
//  Byte transfer: occurs on a posedge with in_valid=1 and in_ready=1.
//   in_ready is combinational from state: 1 only in HI and LO.
//  FSM:
//   IDLE : load_start -> HI; addr<=BASE_ADDR, word_count<=0, done<=0, full<=0.
//   HI   : on transfer, latch hi<=in_byte -> LO.
//   LO   : on transfer, w={hi,in_byte}.
//          if w==END_WORD -> DONE, no write.
//          else -> WRITE with mem_data<=w and mem_address<=addr.
//   WRITE: mem_wren=1 for exactly this cycle; addr<=addr+1 (mod 2^ADDR_W);
//          word_count<=word_count+1.
//          if word_count+1==MAX_WORDS -> DONE with full<=1; else -> HI.
//   DONE : done=1, busy=0; load_start -> HI with the same init as IDLE.
//  Latency: low-byte transfer at edge N -> mem_wren high in cycle N+1.
//   The next high byte can be accepted at edge N+2.
//  mem_address/mem_data hold their last values outside WRITE.
//   mem_wren=0 outside WRITE.
//  load_start while busy: ignored; no state change.
//  in_valid with in_ready=0: byte not consumed; the source holds it.
//  Address wrap: BASE_ADDR+k wraps modulo 2^ADDR_W; no error flag.
//  An END_WORD-valued instruction cannot be loaded; an END_WORD arriving exactly
//   after MAX_WORDS writes is never accepted (already DONE).
//  An odd trailing byte (load left in LO) stays pending until more bytes arrive
//   or reset.
// TESTING
//  T1 reset -> load_start; bytes 12,34,AB,CD,FF,FF -> wren at addr 0 data 1234,
//     addr 1 data ABCD; done=1, word_count=2, full=0.
//  T2 in_valid toggled randomly with gaps -> same memory image as T1; no
//     duplicated or dropped bytes.
//  T3 MAX_WORDS=4, stream 5 words, no terminator -> 4 writes at addr 0..3; done=1,
//     full=1, in_ready=0 for the 5th word.
//  T4 BASE_ADDR=1022, 3 words + FFFF -> writes at 1022, 1023, 0; word_count=3.
//  T5 reset_n=0 asserted in the WRITE cycle -> mem_wren falls asynchronously;
//     all outputs 0; state IDLE.
//  T6 load_start pulsed during LO -> ignored; a second load_start after done
//     restarts at BASE_ADDR with word_count=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the loader.
// The master side is the loader itself; the slave side is the byte source and memory.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [15:0]       mem_data;
    logic              mem_wren;

    modport master (
        input  in_valid, in_byte,
        output in_ready, mem_address, mem_data, mem_wren
    );

    modport slave (
        output in_valid, in_byte,
        input  in_ready, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 16-bit words
// and writes them to consecutive addresses until a terminator word or MAX_WORDS.
module imem_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024,
    parameter logic [15:0]       END_WORD  = 16'hFFFF
) (
    input  logic          clock,
    input  logic          reset_n,
    imem_loader_if.master bus,
    input  logic          load_start,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic [ADDR_W:0] word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(MAX_WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        hi_q;
    logic [15:0]       word;
    logic              xfer;
    logic              start_ok;
    logic              last_word;

    assign word      = {hi_q, bus.in_byte};
    assign xfer      = bus.in_valid && bus.in_ready;
    assign start_ok  = load_start && (state_q == IDLE || state_q == DONE);
    assign last_word = (word_count == LAST_CNT);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        bus.in_ready = (state_q == HI) || (state_q == LO);
        bus.mem_wren = (state_q == WRITE);
        busy         = (state_q == HI) || (state_q == LO) || (state_q == WRITE);
        done         = (state_q == DONE);

        unique case (state_q)
            IDLE:    if (load_start) state_d = HI;
            HI:      if (xfer) state_d = LO;
            LO:      if (xfer) state_d = (word == END_WORD) ? DONE : WRITE;
            WRITE:   state_d = last_word ? DONE : HI;
            DONE:    if (load_start) state_d = HI;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q          <= '0;
            hi_q            <= '0;
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            word_count      <= '0;
            full            <= 1'b0;
        end else begin
            if (start_ok) begin
                addr_q     <= BASE_ADDR;
                word_count <= '0;
                full       <= 1'b0;
            end

            if (state_q == HI && xfer) begin
                hi_q <= bus.in_byte;
            end

            // The terminator is swallowed here and never reaches the write port.
            if (state_q == LO && xfer && word != END_WORD) begin
                bus.mem_data    <= word;
                bus.mem_address <= addr_q;
            end

            if (state_q == WRITE) begin
                addr_q     <= addr_q + 1'b1;
                word_count <= word_count + 1'b1;
                if (last_word) full <= 1'b1;
            end
        end
    end

endmodule
